// File: rtl/jt12_wrq_if.sv
// CPU bus and MMR request signals of the JT12 write queue.
// MMR handshake: mmr_write rises with mmr_addr/mmr_din, which stay stable until busy_mmr is seen high on a cen tick; the next request waits for busy_mmr to fall.
interface jt12_wrq_if #(
  parameter int AW = 2,
  parameter int DW = 8
);
  logic          cs_n;
  logic          wr_n;
  logic          rd_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [7:0]    dout;
  logic          busy_mmr;
  logic          mmr_write;
  logic [AW-1:0] mmr_addr;
  logic [DW-1:0] mmr_din;

  modport slave (
    input  cs_n, wr_n, rd_n, addr, din, busy_mmr,
    output dout, mmr_write, mmr_addr, mmr_din
  );

  modport master (
    output cs_n, wr_n, rd_n, addr, din, busy_mmr,
    input  dout, mmr_write, mmr_addr, mmr_din
  );
endinterface

// File: rtl/jt12_wrq.sv
// JT12 CPU write queue: edge-detected CPU writes into a DEPTH-entry FIFO, drained into the MMR block on cen ticks.
// Optional timer interrupt enabled by defining JT12_IRQ_EN; otherwise irq_n is tied high.
module jt12_wrq #(
  parameter int AW        = 2,
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int BUSY_MODE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  jt12_wrq_if.slave              bus,
  input  logic                   flag_A,
  input  logic                   flag_B,
  input  logic [1:0]             irq_mask,
  output logic                   irq_n,
  output logic [$clog2(DEPTH):0] level,
  output logic [1:0]             o_dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_wr_d;
  logic                r_rd_d;
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [LW-1:0]       r_level;
  logic                r_overflow;
  logic                r_busy;
  logic                r_fa_m;
  logic                r_fa_s;
  logic                r_fb_m;
  logic                r_fb_s;
  logic                r_mmr_write;
  logic [AW-1:0]       r_mmr_addr;
  logic [DW-1:0]       r_mmr_din;
  logic [AW+DW-1:0]    r_mem [DEPTH];

  logic w_wr_raw;
  logic w_rd_raw;
  logic w_wr_edge;
  logic w_rd_edge;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_ovf_set;
  logic w_pop;
  logic w_req_clr;
  logic w_busy_nxt;

  assign w_wr_raw  = !bus.cs_n && !bus.wr_n;
  assign w_rd_raw  = !bus.cs_n && !bus.rd_n;
  assign w_wr_edge = w_wr_raw && !r_wr_d;
  assign w_rd_edge = w_rd_raw && !r_rd_d;
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  // Fullness is judged on the registered level, so a same-cycle pop cannot rescue a push.
  assign w_push    = w_wr_edge && !w_full;
  assign w_ovf_set = w_wr_edge && w_full;
  assign w_busy_nxt = (BUSY_MODE == 0) ? w_full : (!w_empty || (r_state != S_IDLE));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_req_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cen && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (cen && bus.busy_mmr) begin
          w_req_clr   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (cen && !bus.busy_mmr) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {bus.addr, bus.din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_d     <= 1'b0;
      r_rd_d     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_d <= w_wr_raw;
      r_rd_d <= w_rd_raw;
      r_busy <= w_busy_nxt;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      // A fresh overflow wins over a read clear in the same cycle.
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (w_rd_edge) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mmr_write <= 1'b0;
      r_mmr_addr  <= '0;
      r_mmr_din   <= '0;
    end else if (w_pop) begin
      r_mmr_write <= 1'b1;
      {r_mmr_addr, r_mmr_din} <= r_mem[r_rptr];
    end else if (w_req_clr) begin
      r_mmr_write <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fa_m <= 1'b0;
      r_fa_s <= 1'b0;
      r_fb_m <= 1'b0;
      r_fb_s <= 1'b0;
    end else begin
      r_fa_m <= flag_A;
      r_fa_s <= r_fa_m;
      r_fb_m <= flag_B;
      r_fb_s <= r_fb_m;
    end
  end

`ifdef JT12_IRQ_EN
  logic r_irq_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq_n <= 1'b1;
    else        r_irq_n <= !((r_fa_s && irq_mask[0]) || (r_fb_s && irq_mask[1]));
  end

  assign irq_n = r_irq_n;
`else
  logic w_unused_irq_mask;

  assign w_unused_irq_mask = ^irq_mask;
  assign irq_n             = 1'b1;
`endif

  assign bus.dout      = {r_busy, r_overflow, 4'b0000, r_fb_s, r_fa_s};
  assign bus.mmr_write = r_mmr_write;
  assign bus.mmr_addr  = r_mmr_addr;
  assign bus.mmr_din   = r_mmr_din;
  assign level         = r_level;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/jt12_wrq.md
# jt12_wrq

Parametrised CPU-side write queue and status port for the JT12 core, replacing the single-entry write latch in front of the memory-mapped register (MMR) block. It accepts CPU bus writes on the system clock, stores them in a DEPTH-entry FIFO, and drains them one at a time into the MMR block on core clock-enable ticks, using the MMR busy handshake. It also builds the status byte (busy, overflow, timer flags) and, optionally, a timer interrupt.

## Interface
- `AW`, 2: CPU address width.
- `DW`, 8: CPU data width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `BUSY_MODE`, 1: 0 = status busy only when FIFO full; 1 = busy while FIFO non-empty or a transfer is in flight.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cen` in 1: core clock enable; the drain FSM advances only when high.
- `cs_n`, `wr_n`, `rd_n` in 1 each: CPU strobes, active-low.
- `addr` in AW: CPU address.
- `din` in DW: CPU write data.
- `dout` out 8: status byte {busy, overflow, 4'b0, flag_B_s, flag_A_s}.
- `flag_A`, `flag_B` in 1 each: timer flags, asynchronous to the CPU bus.
- `busy_mmr` in 1: MMR block is processing a write.
- `mmr_write` out 1: write request to the MMR block.
- `mmr_addr` out AW; `mmr_din` out DW: request payload; stable while `mmr_write` is high.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `irq_mask` in 2: interrupt enables for {B, A}. Used only with JT12_IRQ_EN.
- `irq_n` out 1: interrupt, active-low.

## Operation
- **Push.**
  - `wr_raw = !cs_n & !wr_n` is registered into `wr_d`.
  - A push happens in the cycle where `wr_raw & !wr_d`, so each CPU access pushes exactly once however long the strobe is held.
  - If the FIFO is full (judged on the registered `level`), the write is dropped and sticky `overflow` is set.
- **Read clear.** On a rising edge of `!cs_n & !rd_n` (edge-detected like writes), `overflow` clears. If a new overflow occurs in the same cycle, `overflow` stays set.
- **Flag sync.** `flag_A` and `flag_B` pass through two flops each to give `flag_A_s` and `flag_B_s`.
- **Drain FSM.** All transitions are qualified by `cen`.
  - IDLE: when FIFO is non-empty, pop the head into `mmr_addr`/`mmr_din`, set `mmr_write=1`, go to REQ.
  - REQ: when `busy_mmr=1`, clear `mmr_write` and go to ACK. Otherwise hold the request.
  - ACK: when `busy_mmr=0`, go to IDLE.
- **Busy bit.**
  - BUSY_MODE=0: `busy = full`.
  - BUSY_MODE=1: `busy = (level!=0) | (state!=IDLE)`.
  - `busy` is registered.
- **Simultaneous push and pop.** Both take effect and `level` is unchanged. A push while full is dropped even if a pop occurs in the same cycle.
- **Pointers.** Read and write pointers wrap modulo DEPTH. `level` ranges 0..DEPTH.
- **Reset.** `rst_n` low clears immediately, including mid-transfer:
  - pointers, `level`, `overflow`, `busy`, `wr_d`, `rd_d` all 0;
  - flag sync flops 0;
  - state IDLE, `mmr_write=0`, `mmr_addr=0`, `mmr_din=0`;
  - `irq_n=1`.
  - A transfer in flight at reset is abandoned, not replayed.

## Timing
- **Push.** A push in cycle N updates `level` at the clk edge ending cycle N.
- **Write latency.** With the FIFO empty and `cen` held high, `mmr_write` rises 2 clk after the strobe falls: push edge, then pop edge.
- **Request lifetime.** `mmr_write` falls on the first `cen` edge at which `busy_mmr` is sampled high.
- **Back-to-back writes.** Consecutive requests are separated by at least one IDLE `cen` tick after `busy_mmr` falls.
- **Status latency.** `dout` flag bits lag the inputs by 2 clk. `busy` and `overflow` lag internal events by 1 clk.
- **Clock enable low.** With `cen` low the FSM is frozen; pushes continue.

## Configuration
- `JT12_IRQ_EN` defined: `irq_n` is registered as `!((flag_A_s & irq_mask[0]) | (flag_B_s & irq_mask[1]))`, reset value 1.
- `JT12_IRQ_EN` undefined: `irq_n` is constant 1 and `irq_mask` is ignored.

## Test plan
- **Single write.** Reset, `cen=1`, write addr=2 din=0x28, model holds `busy_mmr` high for 3 cycles after the request → `mmr_write` high 2 clk after the strobe with addr=2, data=0x28; `dout[7]` returns to 0 after `busy_mmr` falls.
- **Burst and overflow.** DEPTH=4, `cen=0`, 6 writes 0x10..0x15 → `level=4`, `dout=0x40|busy`; enable `cen` → MMR receives exactly 0x10..0x13 in order; a status read clears bit 6.
- **Long strobe.** Hold `wr_n` low for 10 clk → exactly one push (`level` 0→1).
- **Simultaneous push and pop.** Push on the cycle the FSM pops with `level=2` → `level` stays 2.
- **Reset mid-transfer.** Pulse `rst_n` low while in REQ → `mmr_write` drops asynchronously, `level=0`, `dout=0x00`.
- **Interrupt (`JT12_IRQ_EN`).** `irq_mask=2'b01`, raise `flag_B` → `irq_n` stays 1; raise `flag_A` → `irq_n=0` within 3 clk.
